// File: rtl/stepper_seq.sv
// Stepper-motor move sequencer: accepts move commands, times each step with a
// programmable period counter and drives the 4-bit coil pattern directly.
module stepper_seq #(
  parameter int unsigned CNT_W   = 28,
  parameter int unsigned STEPS_W = 16,
  parameter int unsigned POS_W   = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [STEPS_W-1:0] cmd_steps,
  input  logic               cmd_dir,
  input  logic               cmd_half,
  input  logic [CNT_W-1:0]   cmd_period,
  input  logic               abort,
  output logic [3:0]         coils,
  output logic               busy,
  output logic               step_pulse,
  output logic               done,
  output logic               aborted,
  output logic [POS_W-1:0]   position,
  output logic               state_dbg
);

  // Handshake: a command transfers on any rising clk edge where cmd_valid and
  // cmd_ready are both high; cmd_ready depends only on state, never on cmd_valid,
  // and a command offered while cmd_ready is low is dropped, not held.

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic [3:0]         coils_q, coils_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [STEPS_W-1:0] remaining_q, remaining_d;
  logic               dir_q, dir_d;
  logic               half_q, half_d;
  logic [POS_W-1:0]   position_q, position_d;
  logic               step_pulse_q, step_pulse_d;
  logic               done_q, done_d;
  logic               aborted_q, aborted_d;
  logic [2:0]         stride;
  logic               step_due;

  function automatic logic [3:0] phase_pattern(input logic [2:0] i);
    logic [3:0] p;
    case (i)
      3'd0:    p = 4'b0001;
      3'd1:    p = 4'b0011;
      3'd2:    p = 4'b0010;
      3'd3:    p = 4'b0110;
      3'd4:    p = 4'b0100;
      3'd5:    p = 4'b1100;
      3'd6:    p = 4'b1000;
      default: p = 4'b1001;
    endcase
    return p;
  endfunction

  assign stride   = half_q ? 3'd1 : 3'd2;
  assign step_due = (cnt_q == period_q - CNT_W'(1));

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    period_d     = period_q;
    remaining_d  = remaining_q;
    dir_d        = dir_q;
    half_d       = half_q;
    position_d   = position_q;
    step_pulse_d = 1'b0;
    done_d       = 1'b0;
    aborted_d    = 1'b0;

    case (state_q)
      IDLE: begin
        // abort is meaningless here, so a simultaneous command still goes in
        if (cmd_valid) begin
          dir_d    = cmd_dir;
          half_d   = cmd_half;
          period_d = (cmd_period == '0) ? CNT_W'(1) : cmd_period;
          cnt_d    = '0;
          if (cmd_steps == '0) begin
            done_d = 1'b1;
          end else begin
            remaining_d = cmd_steps;
            state_d     = RUN;
          end
        end
      end

      RUN: begin
        if (abort) begin
          state_d     = IDLE;
          aborted_d   = 1'b1;
          remaining_d = '0;
          cnt_d       = '0;
        end else if (step_due) begin
          cnt_d        = '0;
          idx_d        = dir_q ? (idx_q + stride) : (idx_q - stride);
          position_d   = dir_q ? (position_q + POS_W'(1)) : (position_q - POS_W'(1));
          step_pulse_d = 1'b1;
          remaining_d  = remaining_q - STEPS_W'(1);
          if (remaining_q == STEPS_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    // Coils follow the new index on the same edge; in IDLE they hold for torque.
    coils_d = phase_pattern(idx_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= 3'd0;
      coils_q      <= 4'b0001;
      cnt_q        <= '0;
      period_q     <= CNT_W'(1);
      remaining_q  <= '0;
      dir_q        <= 1'b1;
      half_q       <= 1'b0;
      position_q   <= '0;
      step_pulse_q <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      coils_q      <= coils_d;
      cnt_q        <= cnt_d;
      period_q     <= period_d;
      remaining_q  <= remaining_d;
      dir_q        <= dir_d;
      half_q       <= half_d;
      position_q   <= position_d;
      step_pulse_q <= step_pulse_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign busy       = (state_q == RUN);
  assign state_dbg  = state_q;
  assign coils      = coils_q;
  assign step_pulse = step_pulse_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign position   = position_q;

endmodule

// File: doc/stepper_seq.md
# stepper_seq

Stepper-motor move sequencer. It accepts move commands (step count, direction, half/full-step mode, step period) over a valid/ready handshake. It times each step with its own programmable period counter and drives the 4-bit coil pattern directly. It sits between the command/control logic and the motor driver pins, and replaces the fixed-rate divided clock as the step-rate source.

## Interface

- `CNT_W`, 28: width of step period and internal period counter.
- `STEPS_W`, 16: width of the commanded step count.
- `POS_W`, 24: width of the signed position counter.

- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  high when a command can be accepted (state IDLE).
- `cmd_steps`  in  STEPS_W  number of steps to issue (unsigned).
- `cmd_dir`  in  1  1 = forward, 0 = reverse.
- `cmd_half`  in  1  1 = half-step, 0 = full-step.
- `cmd_period`  in  CNT_W  clock cycles per step (unsigned).
- `abort`  in  1  stop current move.
- `coils`  out  4  coil drive pattern.
- `busy`  out  1  high while in RUN.
- `step_pulse`  out  1  one-cycle pulse per issued step.
- `done`  out  1  one-cycle pulse on normal move completion.
- `aborted`  out  1  one-cycle pulse on abort.
- `position`  out  POS_W  signed step position.

## Operation

- **States:** IDLE, RUN. `busy` = (state==RUN). `cmd_ready` = (state==IDLE), combinational.
- **Accept:** an edge with `cmd_valid && cmd_ready`.
  - Latches steps, dir, half, and period P. `cmd_period`==0 is latched as 1.
  - Clears the period counter `cnt` to 0.
  - If steps==0: stays IDLE, `done`<=1, no coil change.
  - Otherwise: goes to RUN with `remaining`=steps.
- **RUN, each edge:**
  - If `abort`: go to IDLE, `aborted`<=1. No step is taken, even if `cnt`==P-1. `remaining` and `cnt` are discarded.
  - Else if `cnt`==P-1: this is a step.
    - `cnt`<=0.
    - Phase index `idx` advances by ±1 (half) or ±2 (full), mod 8. Forward = +, reverse = -.
    - `position` += 1 (forward) or -= 1 (reverse), regardless of step mode.
    - `step_pulse`<=1 and `remaining`-=1.
    - If `remaining` was 1: go to IDLE and `done`<=1 on the same edge.
  - Else: `cnt`+=1.
- **Command gating:**
  - `cmd_valid` while busy is ignored. It is not queued.
  - `abort` in IDLE is ignored.
  - `abort` together with `cmd_valid` in IDLE: the command is accepted.
- **Phase table** (`coils` = table[idx], registered):
  - idx 0: 0001, 1: 0011, 2: 0010, 3: 0110
  - idx 4: 0100, 5: 1100, 6: 1000, 7: 1001
- **Coil hold:** coils hold the last pattern in IDLE (holding torque). `idx` persists across commands.
- **Mixed modes:** a full-step move starting from an odd `idx` steps through odd entries (two-coil full step). This is legal.
- **Wrap-around:**
  - `idx` wraps mod 8.
  - `position` wraps in two's complement, with no saturation.
- **Reset** (also mid-move):
  - State IDLE, `idx`=0, `coils`=0001, `cnt`=0, `remaining`=0, `position`=0.
  - `busy`, `step_pulse`, `done`, `aborted` = 0; `cmd_ready`=1.

## Timing

- Accept edge E0: the first step takes effect at edge E_P. `coils`, `position`, and `step_pulse` are all visible after E_P.
- Step k takes effect at edge E_{k·P}. Step spacing is exactly P cycles. With P=1, one step occurs per cycle.
- Last step (k=N): `done` is high in the cycle after E_{N·P}. `cmd_ready` is high in that same cycle. A new command can be accepted at E_{N·P+1}.
- steps==0: `done` is high in the cycle after E0. `busy` never rises.
- `abort` sampled at edge Ea: `aborted` is high and `busy` is low after Ea. The step count is the number of steps completed before Ea.
- All outputs are registered except `cmd_ready`.

## Test plan

- **Reset:** assert `rst` 2 cycles → `coils`=0001, `position`=0, `busy`=0, `cmd_ready`=1, all pulses 0. Repeat with `rst` mid-move (steps=10, P=3, after 7 cycles) → same values on the next cycle.
- **Full-step forward:** steps=3, dir=1, half=0, P=4, from idx0.
  - `coils` goes 0010 @E4, 0100 @E8, 1000 @E12.
  - Exactly 3 `step_pulse`.
  - `done` after E12, `position`=3.
- **Half-step reverse:** steps=2, dir=0, half=1, P=0 (treated as 1), from idx0 → `coils` 1001 @E1, 1000 @E2, `done` after E2, `position`=-2.
- **Zero steps:** steps=0 → `done` the next cycle, `busy` stays 0, `coils` unchanged.
- **Abort and gating:** steps=10, P=5; assert `abort` at E12.
  - Exactly 2 steps taken, `aborted`=1 for one cycle, `done` never asserted, `position`=2.
  - A `cmd_valid` pulse at E3 (while busy) is ignored: `cmd_ready`=0.
- **Index wrap:** steps=9, half=1, forward, P=2, from idx0 → final `coils`=0011 (idx1), `position`=9. Then a full-step forward move of 1 step → 0110 (idx3).
